// File: rtl/network_sequencer.sv
// Drives one shared layer datapath through LAYERS passes per inference, feeding each
// activated result back as the next operand, with settle filtering and a per-layer timeout.
module network_sequencer #(
    parameter int LAYERS  = 3,
    parameter int VLEN    = 4,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [32*VLEN-1:0]   in_data,
    output logic [3:0]           layer_idx,
    output logic [32*VLEN-1:0]   layer_data,
    output logic                 layer_start,
    input  logic [32*VLEN-1:0]   layer_result,
    input  logic                 layer_done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [32*VLEN-1:0]   out_data,
    output logic                 error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_OUTPUT
    } state_t;

    localparam int             WW        = $clog2(TIMEOUT + 1);
    localparam logic [3:0]     SETTLE_W  = 4'(SETTLE);
    localparam logic [3:0]     LAST_W    = 4'(LAYERS - 1);
    localparam logic [WW-1:0]  TIMEOUT_W = WW'(TIMEOUT);

    state_t              state_q;
    logic [32*VLEN-1:0]  data_q;
    logic [3:0]          layer_idx_q;
    logic [3:0]          settle_q;
    logic [3:0]          settle_d;
    logic [WW-1:0]       wait_q;
    logic [WW-1:0]       wait_d;
    logic                in_ready_q;
    logic                layer_start_q;
    logic                out_valid_q;
    logic                error_q;
    logic                capture;
    logic                timed_out;

    // A low layer_done forces the count back to zero, so only an unbroken run can capture.
    assign settle_d  = layer_done ? settle_q + 4'd1 : 4'd0;
    assign wait_d    = wait_q + WW'(1);
    assign capture   = (settle_d == SETTLE_W);
    assign timed_out = (wait_d == TIMEOUT_W);

    // NOTE: data_q is an ordinary register, not a RAM, so it is cleared by reset along with
    // the control state; no stale vector from an aborted inference can reach out_data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            data_q        <= '0;
            layer_idx_q   <= '0;
            settle_q      <= '0;
            wait_q        <= '0;
            in_ready_q    <= 1'b1;
            layer_start_q <= 1'b0;
            out_valid_q   <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            layer_start_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        data_q        <= in_data;
                        layer_idx_q   <= '0;
                        in_ready_q    <= 1'b0;
                        layer_start_q <= 1'b1;
                        state_q       <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    settle_q <= '0;
                    wait_q   <= '0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    settle_q <= settle_d;
                    wait_q   <= wait_d;
                    // Capture wins over a timeout landing on the same edge.
                    if (capture) begin
                        data_q <= layer_result;
                        if (layer_idx_q == LAST_W) begin
                            out_valid_q <= 1'b1;
                            state_q     <= S_OUTPUT;
                        end else begin
                            layer_idx_q   <= layer_idx_q + 4'd1;
                            layer_start_q <= 1'b1;
                            state_q       <= S_LAUNCH;
                        end
                    end else if (timed_out) begin
                        error_q     <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        error_q     <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign layer_idx   = layer_idx_q;
    assign layer_data  = data_q;
    assign layer_start = layer_start_q;
    assign out_valid   = out_valid_q;
    assign out_data    = data_q;
    assign error       = error_q;

endmodule

// File: tb/tb_network_sequencer.sv
// Directed bench for network_sequencer: a stub layer adds 1.0 to every word of its operand.
module tb_network_sequencer;

    localparam int VLEN = 4;
    localparam int W    = 32 * VLEN;

    localparam logic [31:0] F1 = 32'h3F80_0000;
    localparam logic [31:0] F2 = 32'h4000_0000;
    localparam logic [31:0] F3 = 32'h4040_0000;
    localparam logic [31:0] F4 = 32'h4080_0000;
    localparam logic [31:0] F5 = 32'h40A0_0000;
    localparam logic [31:0] F6 = 32'h40C0_0000;
    localparam logic [31:0] F7 = 32'h40E0_0000;
    localparam logic [31:0] F8 = 32'h4100_0000;

    localparam logic [W-1:0] ALL1  = {4{F1}};
    localparam logic [W-1:0] ALL2  = {4{F2}};
    localparam logic [W-1:0] ALL4  = {4{F4}};
    localparam logic [W-1:0] ALL5  = {4{F5}};
    localparam logic [W-1:0] V1234 = {F4, F3, F2, F1};
    localparam logic [W-1:0] V4567 = {F7, F6, F5, F4};
    localparam logic [W-1:0] V5678 = {F8, F7, F6, F5};

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [3:0]    layer_idx;
    logic [W-1:0]  layer_data;
    logic          layer_start;
    logic [W-1:0]  layer_result;
    logic          layer_done;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          error;

    int n_checks = 0;
    int n_fail   = 0;

    int         start_total = 0;
    int         dbl_start   = 0;
    int         bad_start   = 0;
    logic       prev_start  = 1'b0;
    logic [11:0] idx_hist   = '0;

    network_sequencer #(
        .LAYERS (3),
        .VLEN   (VLEN),
        .SETTLE (2),
        .TIMEOUT(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .layer_idx   (layer_idx),
        .layer_data  (layer_data),
        .layer_start (layer_start),
        .layer_result(layer_result),
        .layer_done  (layer_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small lookup of +1.0 for the integral floats used here; anything else gets a marker value.
    function automatic logic [31:0] plus1(input logic [31:0] w);
        case (w)
            32'h0000_0000: return F1;
            F1:            return F2;
            F2:            return F3;
            F3:            return F4;
            F4:            return F5;
            F5:            return F6;
            F6:            return F7;
            F7:            return F8;
            default:       return w + 32'd1;
        endcase
    endfunction

    function automatic logic [W-1:0] vec_plus1(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < VLEN; i++) r[i*32 +: 32] = plus1(v[i*32 +: 32]);
        return r;
    endfunction

    assign layer_result = vec_plus1(layer_data);

    always @(posedge clk) begin
        if (layer_start === 1'b1) begin
            start_total <= start_total + 1;
            idx_hist    <= {idx_hist[7:0], layer_idx};
            if (prev_start) dbl_start <= dbl_start + 1;
            if (in_ready || out_valid) bad_start <= bad_start + 1;
        end
        prev_start <= (layer_start === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [W-1:0] v);
        in_data  = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; layer_done = 1'b0; in_data = '0;
        repeat (3) tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (layer_start !== 1'b0) begin n_fail++; $display("FAIL reset_layer_start: got %b want 0", layer_start); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
        n_checks++; if (layer_idx !== 4'd0) begin n_fail++; $display("FAIL reset_layer_idx: got %0d want 0", layer_idx); end
        n_checks++; if (layer_data !== '0) begin n_fail++; $display("FAIL reset_layer_data: got %h want 0", layer_data); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_main();
        int lat;
        int s0;
        s0 = start_total;
        layer_done = 1'b1;
        accept(ALL1);
        wait_out(lat);
        n_checks++; if (lat != 9) begin n_fail++; $display("FAIL main_latency: got %0d want 9", lat); end
        n_checks++; if (out_data !== ALL4) begin n_fail++; $display("FAIL main_out_data: got %h want %h", out_data, ALL4); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL main_error: got %b want 0", error); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL main_in_ready: got %b want 0", in_ready); end
        n_checks++; if (start_total - s0 != 3) begin n_fail++; $display("FAIL main_starts: got %0d want 3", start_total - s0); end
        n_checks++; if (idx_hist !== 12'h012) begin n_fail++; $display("FAIL main_idx_seq: got %h want 012", idx_hist); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL main_release_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL main_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_glitch();
        int lat;
        int s0;
        logic [4:0] pat;
        pat = 5'b11010;
        s0  = start_total;
        lat = -1;
        layer_done = 1'b0;
        accept(V1234);
        for (int i = 0; i < 40; i++) begin
            layer_done = pat[i % 5];
            tick();
            if (out_valid === 1'b1) begin
                lat = i + 1;
                break;
            end
        end
        n_checks++; if (lat != 15) begin n_fail++; $display("FAIL glitch_latency: got %0d want 15", lat); end
        n_checks++; if (out_data !== V4567) begin n_fail++; $display("FAIL glitch_out_data: got %h want %h", out_data, V4567); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL glitch_error: got %b want 0", error); end
        n_checks++; if (start_total - s0 != 3) begin n_fail++; $display("FAIL glitch_starts: got %0d want 3", start_total - s0); end
        n_checks++; if (idx_hist !== 12'h012) begin n_fail++; $display("FAIL glitch_idx_seq: got %h want 012", idx_hist); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        layer_done = 1'b1;
    endtask

    task automatic test_timeout();
        int lat;
        int s0;
        s0 = start_total;
        layer_done = 1'b0;
        accept(V5678);
        wait_out(lat);
        n_checks++; if (lat != 9) begin n_fail++; $display("FAIL timeout_latency: got %0d want 9", lat); end
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL timeout_error: got %b want 1", error); end
        n_checks++; if (out_data !== V5678) begin n_fail++; $display("FAIL timeout_out_data: got %h want %h", out_data, V5678); end
        n_checks++; if (layer_idx !== 4'd0) begin n_fail++; $display("FAIL timeout_layer_idx: got %0d want 0", layer_idx); end
        n_checks++; if (start_total - s0 != 1) begin n_fail++; $display("FAIL timeout_starts: got %0d want 1", start_total - s0); end
    endtask

    // Entered with the timed-out result still pending.
    task automatic test_hold();
        in_data  = V1234;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b want 1", i, out_valid); end
            n_checks++; if (out_data !== V5678) begin n_fail++; $display("FAIL hold_data[%0d]: got %h want %h", i, out_data, V5678); end
            n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL hold_error[%0d]: got %b want 1", i, error); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_valid: got %b want 0", out_valid); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL hold_release_error: got %b want 0", error); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_ready: got %b want 1", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_idle_valid: got %b want 0", out_valid); end
        layer_done = 1'b1;
    endtask

    task automatic test_reset_mid();
        int s0;
        layer_done = 1'b1;
        accept(ALL1);
        repeat (4) tick();
        n_checks++; if (layer_idx !== 4'd1) begin n_fail++; $display("FAIL midrst_pre_idx: got %0d want 1", layer_idx); end
        s0 = start_total;
        rst_n = 1'b0;
        tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        n_checks++; if (layer_idx !== 4'd0) begin n_fail++; $display("FAIL midrst_layer_idx: got %0d want 0", layer_idx); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        n_checks++; if (layer_start !== 1'b0) begin n_fail++; $display("FAIL midrst_layer_start: got %b want 0", layer_start); end
        n_checks++; if (layer_data !== '0) begin n_fail++; $display("FAIL midrst_layer_data: got %h want 0", layer_data); end
        rst_n = 1'b1;
        repeat (3) tick();
        n_checks++; if (start_total != s0) begin n_fail++; $display("FAIL midrst_starts: got %0d want %0d", start_total, s0); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_idle_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] vin  [3];
        logic [W-1:0] vexp [3];
        int acc;
        int outs;
        int s0;
        vin[0] = ALL1;  vexp[0] = ALL4;
        vin[1] = V1234; vexp[1] = V4567;
        vin[2] = ALL2;  vexp[2] = ALL5;
        acc = 0; outs = 0;
        s0 = start_total;
        layer_done = 1'b1;
        out_ready  = 1'b1;
        in_data    = vin[0];
        in_valid   = 1'b1;
        for (int cyc = 0; cyc < 200 && outs < 3; cyc++) begin
            logic will_accept;
            will_accept = in_valid && in_ready;
            tick();
            if (will_accept) begin
                acc++;
                if (acc < 3) in_data = vin[acc];
                else in_valid = 1'b0;
            end
            if (out_valid === 1'b1) begin
                n_checks++;
                if (outs >= 3 || out_data !== vexp[outs]) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d]: got %h want %h", outs, out_data, vexp[outs % 3]);
                end
                outs++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++; if (acc != 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 3", acc); end
        n_checks++; if (outs != 3) begin n_fail++; $display("FAIL b2b_outputs: got %0d want 3", outs); end
        n_checks++; if (start_total - s0 != 9) begin n_fail++; $display("FAIL b2b_starts: got %0d want 9", start_total - s0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_main();
        test_glitch();
        test_timeout();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        tick();
        n_checks++; if (dbl_start != 0) begin n_fail++; $display("FAIL start_width: got %0d multi-cycle pulses want 0", dbl_start); end
        n_checks++; if (bad_start != 0) begin n_fail++; $display("FAIL start_outside_launch: got %0d want 0", bad_start); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
